// File: rtl/pe_mac_os.sv
// Output-stationary systolic PE: forwards operands east/south, MACs into a saturating/wrapping accumulator, drains via a psum chain.
// Latency: operand pass-through 1 cycle; MAC result on acc 1 cycle after a valid pair; drain emits own result 2 cycles after drain pulse.
// Backpressure: none; operands and psums move every cycle, the valid bits qualify them, busy flags the drain window.
//
// Ports:
//   clk, rst                         clock (rising edge), asynchronous active-low reset
//   a_in/a_valid_in -> a_out/...     west operand in, east operand out (registered)
//   b_in/b_valid_in -> b_out/...     north operand in, south operand out (registered)
//   acc_clr, drain                   single-cycle control pulses (honoured only in COMPUTE)
//   psum_in/psum_valid_in            drain chain from the PE to the north
//   psum_out/psum_valid_out          drain chain to the PE to the south
//   acc, mac_count                   live accumulator and MAC count of the current tile
//   ovf_flag, pair_err, busy         sticky overflow, sticky operand-pairing error, drain in progress
//
// ACC_W must be at least 2*DATA_W so a single product always fits.
module pe_mac_os #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1,
  parameter int ROW_IDX  = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_valid_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid_out,
  input  logic              acc_clr,
  input  logic              drain,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              psum_valid_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_valid_out,
  output logic [ACC_W-1:0]  acc,
  output logic [CNT_W-1:0]  mac_count,
  output logic              ovf_flag,
  output logic              pair_err,
  output logic              busy
);

  // pass_cnt only has to reach ROW_IDX-1; keep at least one bit for ROW_IDX of 0 or 1.
  localparam int              PC_W      = (ROW_IDX > 1) ? $clog2(ROW_IDX) : 1;
  localparam logic [PC_W-1:0] PASS_LAST = PC_W'(ROW_IDX - 1);

  localparam logic             IS_SIGNED = (SIGNED != 0);
  localparam logic             DO_SAT    = (SATURATE != 0);
  localparam logic [ACC_W-1:0] ACC_MAX   = IS_SIGNED ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_MIN   = IS_SIGNED ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};

  typedef enum logic [1:0] {
    COMPUTE    = 2'd0,
    DRAIN_SELF = 2'd1,
    DRAIN_PASS = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pass_cnt;

  logic pair_vld;
  logic pair_one;
  assign pair_vld = a_valid_in & b_valid_in;
  assign pair_one = a_valid_in ^ b_valid_in;

  // ---------------------------------------------------------------------------
  // MAC datapath. Operands are extended to 2*DATA_W before the multiply so the
  // low 2*DATA_W bits of the product are correct for both signed and unsigned.
  // The sum is formed one bit wider than the accumulator so overflow is exact.
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0] a_x;
  logic [2*DATA_W-1:0] b_x;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      prod_ext;
  logic [ACC_W-1:0]    acc_base;
  logic [ACC_W:0]      base_ext;
  logic [ACC_W:0]      sum;
  logic                mac_ovf;
  logic [ACC_W-1:0]    mac_res;

  assign a_x      = {{DATA_W{IS_SIGNED & a_in[DATA_W-1]}}, a_in};
  assign b_x      = {{DATA_W{IS_SIGNED & b_in[DATA_W-1]}}, b_in};
  assign prod     = a_x * b_x;
  assign prod_ext = {{(ACC_W+1-2*DATA_W){IS_SIGNED & prod[2*DATA_W-1]}}, prod};

  // A clear coinciding with a pair starts the new tile from the product alone.
  assign acc_base = acc_clr ? '0 : acc;
  assign base_ext = {IS_SIGNED & acc_base[ACC_W-1], acc_base};
  assign sum      = base_ext + prod_ext;

  // Signed: the two top bits disagree when the true sum left the range.
  // Unsigned: any carry out is an overflow, and it can only be upward.
  assign mac_ovf = IS_SIGNED ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];

  always_comb begin
    mac_res = sum[ACC_W-1:0];
    if (mac_ovf && DO_SAT) begin
      mac_res = (IS_SIGNED && sum[ACC_W]) ? ACC_MIN : ACC_MAX;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COMPUTE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COMPUTE: begin
        if (drain) begin
          state_nxt = DRAIN_SELF;
        end
      end
      DRAIN_SELF: begin
        // Row 0 has nobody to the north, so it is done after its own result.
        state_nxt = (ROW_IDX == 0) ? COMPUTE : DRAIN_PASS;
      end
      DRAIN_PASS: begin
        if (psum_valid_in && (pass_cnt == PASS_LAST)) begin
          state_nxt = COMPUTE;
        end
      end
      default: begin
        state_nxt = COMPUTE;
      end
    endcase
  end

  assign busy = (state != COMPUTE);

  // ---------------------------------------------------------------------------
  // Operand forwarding: unconditional, valid bits ride alongside the data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator, counters, flags and drain chain
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc            <= '0;
      mac_count      <= '0;
      ovf_flag       <= 1'b0;
      pair_err       <= 1'b0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      pass_cnt       <= '0;
    end else begin
      case (state)
        COMPUTE: begin
          psum_valid_out <= 1'b0;
          if (acc_clr) begin
            acc       <= '0;
            mac_count <= '0;
            ovf_flag  <= 1'b0;
            pair_err  <= 1'b0;
          end
          if (pair_vld) begin
            acc <= mac_res;
            if (acc_clr) begin
              mac_count <= CNT_W'(1);
            end else if (!(&mac_count)) begin
              mac_count <= mac_count + CNT_W'(1);
            end
            if (mac_ovf) begin
              ovf_flag <= 1'b1;
            end
          end
          // A lone valid is an error seen in the new tile, so it survives a clear.
          if (pair_one) begin
            pair_err <= 1'b1;
          end
        end
        DRAIN_SELF: begin
          psum_out       <= acc;
          psum_valid_out <= 1'b1;
          acc            <= '0;
          mac_count      <= '0;
          ovf_flag       <= 1'b0;
          pass_cnt       <= '0;
          if (pair_vld || pair_one) begin
            pair_err <= 1'b1;
          end
        end
        DRAIN_PASS: begin
          psum_out       <= psum_in;
          psum_valid_out <= psum_valid_in;
          if (psum_valid_in) begin
            pass_cnt <= pass_cnt + PC_W'(1);
          end
          if (pair_vld || pair_one) begin
            pair_err <= 1'b1;
          end
        end
        default: begin
          psum_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_os.sv
// Bench for pe_mac_os: three instances (unsigned 8/32 saturating ROW_IDX=2,
// signed 8/16 saturating, signed 8/16 wrapping) checked against an arithmetic
// reference model of the accumulator plus hand-derived drain sequences.
module tb_pe_mac_os;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // unsigned instance
  logic [7:0]  ua, ub, ua_o, ub_o;
  logic        uav, ubv, uclr, udrain, uav_o, ubv_o;
  logic [31:0] upin, upo, uacc;
  logic        upv, upvo;
  logic [15:0] ucnt;
  logic        uovf, uerr, ubusy;

  // signed instances share their inputs
  logic [7:0]  sa, sb;
  logic        sav, sbv, sclr, sdrain;
  logic [15:0] spin;
  logic        spv;
  logic [7:0]  ss_ao, ss_bo, sw_ao, sw_bo;
  logic        ss_avo, ss_bvo, sw_avo, sw_bvo;
  logic [15:0] ss_po, sw_po, ss_acc, sw_acc;
  logic        ss_pvo, sw_pvo;
  logic [3:0]  ss_cnt, sw_cnt;
  logic        ss_ovf, sw_ovf, ss_err, sw_err, ss_busy, sw_busy;

  pe_mac_os #(.DATA_W(8), .ACC_W(32), .SIGNED(0), .SATURATE(1), .ROW_IDX(2), .CNT_W(16)) u_u (
    .clk(clk), .rst(rst),
    .a_in(ua), .a_valid_in(uav), .b_in(ub), .b_valid_in(ubv),
    .a_out(ua_o), .a_valid_out(uav_o), .b_out(ub_o), .b_valid_out(ubv_o),
    .acc_clr(uclr), .drain(udrain),
    .psum_in(upin), .psum_valid_in(upv), .psum_out(upo), .psum_valid_out(upvo),
    .acc(uacc), .mac_count(ucnt), .ovf_flag(uovf), .pair_err(uerr), .busy(ubusy));

  pe_mac_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1), .ROW_IDX(0), .CNT_W(4)) u_ss (
    .clk(clk), .rst(rst),
    .a_in(sa), .a_valid_in(sav), .b_in(sb), .b_valid_in(sbv),
    .a_out(ss_ao), .a_valid_out(ss_avo), .b_out(ss_bo), .b_valid_out(ss_bvo),
    .acc_clr(sclr), .drain(sdrain),
    .psum_in(spin), .psum_valid_in(spv), .psum_out(ss_po), .psum_valid_out(ss_pvo),
    .acc(ss_acc), .mac_count(ss_cnt), .ovf_flag(ss_ovf), .pair_err(ss_err), .busy(ss_busy));

  pe_mac_os #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0), .ROW_IDX(0), .CNT_W(4)) u_sw (
    .clk(clk), .rst(rst),
    .a_in(sa), .a_valid_in(sav), .b_in(sb), .b_valid_in(sbv),
    .a_out(sw_ao), .a_valid_out(sw_avo), .b_out(sw_bo), .b_valid_out(sw_bvo),
    .acc_clr(sclr), .drain(sdrain),
    .psum_in(spin), .psum_valid_in(spv), .psum_out(sw_po), .psum_valid_out(sw_pvo),
    .acc(sw_acc), .mac_count(sw_cnt), .ovf_flag(sw_ovf), .pair_err(sw_err), .busy(sw_busy));

  // ---------------- reference model ----------------
  longint mu_acc, ms_acc, mw_acc;
  int     mu_cnt, ms_cnt;
  bit     mu_ovf, ms_ovf, mw_ovf;

  // acc + prod over the integers, then clamp or wrap into a w-bit range.
  function automatic longint ref_mac(input longint a, input longint p, input int w,
                                     input bit sgn, input bit sat, output bit ovf);
    longint s, mx, mn, m;
    m = longint'(1) << w;
    if (sgn) begin mx = m / 2 - 1; mn = -(m / 2); end
    else     begin mx = m - 1;     mn = 0;        end
    s   = a + p;
    ovf = (s > mx) || (s < mn);
    if (!ovf) return s;
    if (sat) return (s > mx) ? mx : mn;
    s = s % m;
    if (s < 0) s = s + m;
    if (sgn && s > mx) s = s - m;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic u_mac(input int a, input int b, input bit clr);
    bit o;
    ua = 8'(a); ub = 8'(b); uav = 1'b1; ubv = 1'b1; uclr = clr;
    step();
    uav = 1'b0; ubv = 1'b0; uclr = 1'b0;
    if (clr) begin mu_acc = 0; mu_cnt = 0; mu_ovf = 0; end
    mu_acc = ref_mac(mu_acc, longint'(a) * longint'(b), 32, 1'b0, 1'b1, o);
    mu_ovf = mu_ovf | o;
    mu_cnt++;
  endtask

  task automatic s_mac(input int a, input int b, input bit clr);
    bit o1, o2;
    sa = 8'(a); sb = 8'(b); sav = 1'b1; sbv = 1'b1; sclr = clr;
    step();
    sav = 1'b0; sbv = 1'b0; sclr = 1'b0;
    if (clr) begin ms_acc = 0; mw_acc = 0; ms_cnt = 0; ms_ovf = 0; mw_ovf = 0; end
    ms_acc = ref_mac(ms_acc, longint'(a) * longint'(b), 16, 1'b1, 1'b1, o1);
    mw_acc = ref_mac(mw_acc, longint'(a) * longint'(b), 16, 1'b1, 1'b0, o2);
    ms_ovf = ms_ovf | o1;
    mw_ovf = mw_ovf | o2;
    if (ms_cnt < 15) ms_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ua = 8'hA5; uav = 1'b1;
    #12;
    checks++; if (ua_o !== 8'h00) begin failures++; $display("FAIL rst_a_out got=%0h exp=0", ua_o); end
    checks++; if (uav_o !== 1'b0) begin failures++; $display("FAIL rst_a_valid got=%0b exp=0", uav_o); end
    checks++; if ({uacc, ucnt, uovf, uerr, upo, upvo, ubusy} !== '0) begin failures++; $display("FAIL rst_u_state got=%0h exp=0", {uacc, ucnt, uovf, uerr, upo, upvo, ubusy}); end
    checks++; if ({ss_acc, ss_cnt, sw_acc, sw_busy} !== '0) begin failures++; $display("FAIL rst_s_state got=%0h exp=0", {ss_acc, ss_cnt, sw_acc, sw_busy}); end
    ua = 8'h00; uav = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_unsigned_mac();
    int ea[3] = '{3, 5, 255};
    int eb[3] = '{6, 6, 255};
    for (int i = 0; i < 3; i++) begin
      u_mac(ea[i], eb[i], 1'b0);
      checks++; if (uacc !== 32'(mu_acc)) begin failures++; $display("FAIL u_acc[%0d] got=%0d exp=%0d", i, uacc, mu_acc); end
      checks++; if (ua_o !== 8'(ea[i]) || ub_o !== 8'(eb[i]) || uav_o !== 1'b1) begin failures++; $display("FAIL u_fwd[%0d] got=%0d/%0d/%0b exp=%0d/%0d/1", i, ua_o, ub_o, uav_o, ea[i], eb[i]); end
    end
    checks++; if (ucnt !== 16'(mu_cnt)) begin failures++; $display("FAIL u_count got=%0d exp=%0d", ucnt, mu_cnt); end
    // data moves even with valid low, accumulator untouched
    ua = 8'h5A; ub = 8'hC3;
    step();
    checks++; if (ua_o !== 8'h5A || ub_o !== 8'hC3 || uav_o !== 1'b0 || ubv_o !== 1'b0) begin failures++; $display("FAIL u_fwd_novalid got=%0h/%0h/%0b/%0b exp=5a/c3/0/0", ua_o, ub_o, uav_o, ubv_o); end
    checks++; if (uacc !== 32'(mu_acc)) begin failures++; $display("FAIL u_acc_hold got=%0d exp=%0d", uacc, mu_acc); end
    ua = 8'h00; ub = 8'h00;
  endtask

  task automatic test_random_unsigned();
    int a, b;
    u_mac(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) u_mac(a, b, 1'b0);
      else begin ua = 8'(a); ub = 8'(b); step(); end
      checks++; if (uacc !== 32'(mu_acc) || ucnt !== 16'(mu_cnt)) begin failures++; $display("FAIL u_rand[%0d] got=%0d/%0d exp=%0d/%0d", i, uacc, ucnt, mu_acc, mu_cnt); end
    end
    checks++; if (uerr !== 1'b0 || uovf !== 1'b0) begin failures++; $display("FAIL u_rand_flags got=%0b/%0b exp=0/0", uerr, uovf); end
  endtask

  task automatic test_acc_clr();
    ua = 8'd9; uav = 1'b1;
    step();
    uav = 1'b0;
    checks++; if (uerr !== 1'b1 || uacc !== 32'(mu_acc)) begin failures++; $display("FAIL clr_lone_a got=%0b/%0d exp=1/%0d", uerr, uacc, mu_acc); end
    u_mac(2, 7, 1'b1);
    checks++; if (uacc !== 32'd14 || ucnt !== 16'd1) begin failures++; $display("FAIL clr_pair got=%0d/%0d exp=14/1", uacc, ucnt); end
    checks++; if (uerr !== 1'b0 || uovf !== 1'b0) begin failures++; $display("FAIL clr_flags got=%0b/%0b exp=0/0", uerr, uovf); end
    ubv = 1'b1;
    step();
    ubv = 1'b0;
    checks++; if (uerr !== 1'b1 || uacc !== 32'd14) begin failures++; $display("FAIL clr_lone_b got=%0b/%0d exp=1/14", uerr, uacc); end
    uclr = 1'b1;
    step();
    uclr = 1'b0;
    mu_acc = 0; mu_cnt = 0; mu_ovf = 0;
    checks++; if (uerr !== 1'b0 || uacc !== 32'd0 || ucnt !== 16'd0) begin failures++; $display("FAIL clr_only got=%0b/%0d/%0d exp=0/0/0", uerr, uacc, ucnt); end
  endtask

  task automatic test_signed_sat();
    s_mac(100, 100, 1'b1);
    s_mac(100, 100, 1'b0);
    s_mac(100, 100, 1'b0);
    s_mac(50, 40, 1'b0);
    checks++; if (ss_acc !== 16'd32000 || sw_acc !== 16'd32000 || ss_ovf !== 1'b0) begin failures++; $display("FAIL s_preload got=%0d/%0d/%0b exp=32000/32000/0", ss_acc, sw_acc, ss_ovf); end
    s_mac(127, 127, 1'b0);
    checks++; if (ss_acc !== 16'(ms_acc) || ss_ovf !== 1'b1) begin failures++; $display("FAIL s_sat_hi got=%0d/%0b exp=%0d/1", $signed(ss_acc), ss_ovf, ms_acc); end
    checks++; if (sw_acc !== 16'(mw_acc) || sw_ovf !== 1'b1) begin failures++; $display("FAIL s_wrap_hi got=%0d/%0b exp=%0d/1", $signed(sw_acc), sw_ovf, mw_acc); end
    checks++; if (ss_cnt !== 4'd5 || sw_cnt !== 4'd5) begin failures++; $display("FAIL s_count got=%0d/%0d exp=5/5", ss_cnt, sw_cnt); end
    s_mac(-128, 127, 1'b1);
    s_mac(-128, 127, 1'b0);
    checks++; if (ss_ovf !== 1'b0 || ss_acc !== 16'(ms_acc)) begin failures++; $display("FAIL s_neg_mid got=%0d/%0b exp=%0d/0", $signed(ss_acc), ss_ovf, ms_acc); end
    s_mac(-128, 127, 1'b0);
    checks++; if (ss_acc !== 16'(ms_acc) || ss_ovf !== 1'b1) begin failures++; $display("FAIL s_sat_lo got=%0d/%0b exp=%0d/1", $signed(ss_acc), ss_ovf, ms_acc); end
    checks++; if (sw_acc !== 16'(mw_acc) || sw_ovf !== 1'b1) begin failures++; $display("FAIL s_wrap_lo got=%0d/%0b exp=%0d/1", $signed(sw_acc), sw_ovf, mw_acc); end
  endtask

  task automatic test_random_signed();
    s_mac(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b1);
    for (int i = 0; i < 19; i++) begin
      s_mac(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b0);
      checks++; if (ss_acc !== 16'(ms_acc) || ss_ovf !== ms_ovf) begin failures++; $display("FAIL s_rand_sat[%0d] got=%0d/%0b exp=%0d/%0b", i, $signed(ss_acc), ss_ovf, ms_acc, ms_ovf); end
      checks++; if (sw_acc !== 16'(mw_acc) || sw_ovf !== mw_ovf) begin failures++; $display("FAIL s_rand_wrap[%0d] got=%0d/%0b exp=%0d/%0b", i, $signed(sw_acc), sw_ovf, mw_acc, mw_ovf); end
    end
    checks++; if (ss_cnt !== 4'(ms_cnt) || sw_cnt !== 4'd15) begin failures++; $display("FAIL s_count_sat got=%0d/%0d exp=%0d/15", ss_cnt, sw_cnt, ms_cnt); end
  endtask

  task automatic test_drain();
    longint exp_self;
    u_mac(10, 10, 1'b1);
    exp_self = mu_acc;
    udrain = 1'b1;
    step();
    udrain = 1'b0;
    checks++; if (ubusy !== 1'b1 || upvo !== 1'b0) begin failures++; $display("FAIL dr_enter got=%0b/%0b exp=1/0", ubusy, upvo); end
    upin = 32'd11; upv = 1'b1;
    step();
    mu_acc = 0; mu_cnt = 0; mu_ovf = 0;
    checks++; if (upo !== 32'(exp_self) || upvo !== 1'b1 || ubusy !== 1'b1) begin failures++; $display("FAIL dr_self got=%0d/%0b/%0b exp=%0d/1/1", upo, upvo, ubusy, exp_self); end
    checks++; if (uacc !== 32'd0 || ucnt !== 16'd0) begin failures++; $display("FAIL dr_self_clear got=%0d/%0d exp=0/0", uacc, ucnt); end
    step();
    upin = 32'h33; upv = 1'b0;
    checks++; if (upo !== 32'd11 || upvo !== 1'b1 || ubusy !== 1'b1) begin failures++; $display("FAIL dr_pass1 got=%0d/%0b/%0b exp=11/1/1", upo, upvo, ubusy); end
    step();
    upin = 32'd22; upv = 1'b1;
    checks++; if (upvo !== 1'b0 || ubusy !== 1'b1) begin failures++; $display("FAIL dr_gap got=%0b/%0b exp=0/1", upvo, ubusy); end
    step();
    upv = 1'b0; upin = 32'd0;
    checks++; if (upo !== 32'd22 || upvo !== 1'b1 || ubusy !== 1'b0) begin failures++; $display("FAIL dr_pass2 got=%0d/%0b/%0b exp=22/1/0", upo, upvo, ubusy); end
    step();
    checks++; if (upvo !== 1'b0 || upo !== 32'd22 || uacc !== 32'd0) begin failures++; $display("FAIL dr_done got=%0b/%0d/%0d exp=0/22/0", upvo, upo, uacc); end
  endtask

  task automatic test_drain_with_pair();
    u_mac(2, 5, 1'b1);
    udrain = 1'b1;
    u_mac(4, 4, 1'b0);
    udrain = 1'b0;
    checks++; if (uacc !== 32'(mu_acc) || ubusy !== 1'b1) begin failures++; $display("FAIL dp_acc got=%0d/%0b exp=%0d/1", uacc, ubusy, mu_acc); end
    step();
    checks++; if (upo !== 32'd26 || upvo !== 1'b1) begin failures++; $display("FAIL dp_self got=%0d/%0b exp=26/1", upo, upvo); end
    mu_acc = 0; mu_cnt = 0;
    ua = 8'd3; ub = 8'd3; uav = 1'b1; ubv = 1'b1;
    step();
    uav = 1'b0; ubv = 1'b0;
    checks++; if (uerr !== 1'b1 || uacc !== 32'd0 || ucnt !== 16'd0) begin failures++; $display("FAIL dp_pair_err got=%0b/%0d/%0d exp=1/0/0", uerr, uacc, ucnt); end
    upin = 32'd1; upv = 1'b1;
    step();
    step();
    upv = 1'b0;
    checks++; if (ubusy !== 1'b0 || uerr !== 1'b1) begin failures++; $display("FAIL dp_exit got=%0b/%0b exp=0/1", ubusy, uerr); end
    uclr = 1'b1;
    step();
    uclr = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    u_mac(5, 5, 1'b0);
    udrain = 1'b1;
    step();
    udrain = 1'b0;
    step();
    ua = 8'h77; ub = 8'h12; uav = 1'b1; ubv = 1'b1;
    checks++; if (upo !== 32'd25 || ubusy !== 1'b1) begin failures++; $display("FAIL rm_pre got=%0d/%0b exp=25/1", upo, ubusy); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({ua_o, uav_o, ub_o, ubv_o, upo, upvo, uacc, ucnt, uovf, uerr} !== '0) begin failures++; $display("FAIL rm_async got=%0h exp=0", {ua_o, uav_o, ub_o, ubv_o, upo, upvo, uacc, ucnt, uovf, uerr}); end
    checks++; if (ubusy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%0b exp=0", ubusy); end
    step();
    checks++; if ({ua_o, uav_o, uacc, ubusy} !== '0) begin failures++; $display("FAIL rm_held got=%0h exp=0", {ua_o, uav_o, uacc, ubusy}); end
    uav = 1'b0; ubv = 1'b0;
    rst = 1'b1;
    mu_acc = 0; mu_cnt = 0; mu_ovf = 0;
    step();
    u_mac(6, 7, 1'b0);
    checks++; if (uacc !== 32'd42 || ucnt !== 16'd1 || ubusy !== 1'b0) begin failures++; $display("FAIL rm_after got=%0d/%0d/%0b exp=42/1/0", uacc, ucnt, ubusy); end
  endtask

  initial begin
    rst = 1'b0;
    ua = '0; ub = '0; uav = 1'b0; ubv = 1'b0; uclr = 1'b0; udrain = 1'b0; upin = '0; upv = 1'b0;
    sa = '0; sb = '0; sav = 1'b0; sbv = 1'b0; sclr = 1'b0; sdrain = 1'b0; spin = '0; spv = 1'b0;
    mu_acc = 0; ms_acc = 0; mw_acc = 0; mu_cnt = 0; ms_cnt = 0;
    mu_ovf = 0; ms_ovf = 0; mw_ovf = 0;
    test_reset();
    test_unsigned_mac();
    test_random_unsigned();
    test_acc_clr();
    test_signed_sat();
    test_random_signed();
    test_drain();
    test_drain_with_pair();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
